// File: rtl/axi_read_data_buffer.sv
// axi_read_data_buffer
//
// Registered FIFO buffer on an AXI read-data (R) channel. Beats from the RAM are
// pushed on s_axi_r_* and emitted in order on m_axi_r_*. There is no fall-through
// path, so a beat shows up downstream no earlier than one cycle after it was
// accepted. s_axi_r_ready is derived only from the registered occupancy, so the
// upstream ready never depends combinationally on m_axi_r_ready.
//
// Parameters
//   AXI_DATA_WIDTH  R data width in bits
//   AXI_ID_WIDTH    R ID width in bits
//   FIFO_DEPTH      buffered beats (power of two, >= 2)
//
// Ports
//   axi_clk, axi_reset              clock, synchronous active-high reset
//   s_axi_r_{data,id,resp,last,valid}, s_axi_r_ready   upstream R channel
//   m_axi_r_{data,id,resp,last,valid}, m_axi_r_ready   downstream R channel
//   fifo_count                      current occupancy
//   stat_beat_count, stat_burst_count  (only with AXI_READ_DATA_BUFFER_STATS_EN)
//
// Optional feature: define AXI_READ_DATA_BUFFER_STATS_EN to add popped-beat and
// popped-burst counters.
module axi_read_data_buffer #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          axi_clk,
  input  logic                          axi_reset,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_r_data,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_r_id,
  input  logic [1:0]                    s_axi_r_resp,
  input  logic                          s_axi_r_last,
  input  logic                          s_axi_r_valid,
  output logic                          s_axi_r_ready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_r_data,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_r_id,
  output logic [1:0]                    m_axi_r_resp,
  output logic                          m_axi_r_last,
  output logic                          m_axi_r_valid,
  input  logic                          m_axi_r_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef AXI_READ_DATA_BUFFER_STATS_EN
  ,
  output logic [31:0]                   stat_beat_count,
  output logic [15:0]                   stat_burst_count
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [1:0]                resp;
    logic                      last;
  } beat_t;

  beat_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  beat_t           head;

  assign s_axi_r_ready = (count_q < CntW'(FIFO_DEPTH));
  assign m_axi_r_valid = (count_q != '0);
  assign push          = s_axi_r_valid & s_axi_r_ready;
  assign pop           = m_axi_r_valid & m_axi_r_ready;
  assign fifo_count    = count_q;

  // Storage is never cleared, so mask the head while empty to keep the
  // outputs at zero after reset.
  always_comb begin
    head = '0;
    if (m_axi_r_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign m_axi_r_data = head.data;
  assign m_axi_r_id   = head.id;
  assign m_axi_r_resp = head.resp;
  assign m_axi_r_last = head.last;

  // Pointers are exactly PtrW bits wide, so +1 wraps from FIFO_DEPTH-1 to 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: s_axi_r_data, id: s_axi_r_id,
                           resp: s_axi_r_resp, last: s_axi_r_last};
    end
  end

`ifdef AXI_READ_DATA_BUFFER_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (pop) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (m_axi_r_last) begin
        burst_cnt_d = burst_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign stat_beat_count  = beat_cnt_q;
  assign stat_burst_count = burst_cnt_q;
`endif

endmodule

// File: doc/axi_read_data_buffer.md
AXI_READ_DATA_BUFFER -- requirements
Module: axi_read_data_buffer

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning R data width in bits.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 8, meaning R ID width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning number of buffered beats; legal values are powers of two, 2 or more.
REQ-004 SHALL have port axi_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port axi_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports s_axi_r_data/id/resp/last/valid, inputs, widths AXI_DATA_WIDTH/AXI_ID_WIDTH/2/1/1: the upstream R channel from the RAM.
REQ-007 SHALL have port s_axi_r_ready, output, 1 bit: upstream ready, driven into the RAM's axi_r_ready.
REQ-008 SHALL have ports m_axi_r_data/id/resp/last/valid, outputs, widths AXI_DATA_WIDTH/AXI_ID_WIDTH/2/1/1: the downstream R channel toward the master.
REQ-009 SHALL have port m_axi_r_ready, input, 1 bit: downstream ready.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.

Function
REQ-011 SHALL push one beat {data,id,resp,last} when s_axi_r_valid && s_axi_r_ready are both high at a rising edge.
REQ-012 SHALL pop the head beat when m_axi_r_valid && m_axi_r_ready are both high at a rising edge.
REQ-013 SHALL drive s_axi_r_ready = (fifo_count < FIFO_DEPTH) combinationally from registered count only, with no dependence on m_axi_r_ready.
REQ-014 SHALL drive m_axi_r_valid = (fifo_count != 0), and SHALL drive m_axi_r_data/id/resp/last from the head entry.
REQ-015 SHALL have no fall-through path: a beat pushed at edge N becomes visible on m_axi_r_* at the earliest after edge N (one-cycle latency).
REQ-016 SHALL keep m_axi_r_* stable while m_axi_r_valid is high and m_axi_r_ready is low.
REQ-017 SHALL update fifo_count per cycle as follows: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-018 SHALL, when full (count = FIFO_DEPTH), hold s_axi_r_ready low even if a pop occurs in the same cycle; the slot becomes available in the next cycle.
REQ-019 SHALL, when empty, accept a push while m_axi_r_valid stays low that cycle; no pop occurs.
REQ-020 SHALL use read and write pointers of $clog2(FIFO_DEPTH) bits that wrap from FIFO_DEPTH-1 to 0.
REQ-021 SHALL pass resp and last through unmodified and SHALL preserve beat order exactly.

Reset
REQ-022 SHALL, while axi_reset is high at a rising edge, clear the pointers and fifo_count to 0, drive m_axi_r_valid low, and drive s_axi_r_ready high starting from the following cycle.
REQ-023 SHALL discard all buffered beats when reset is asserted mid-burst; stored data contents need not be cleared, and m_axi_r_data/id/resp/last are 0 after reset.

Configuration
REQ-024 SHALL, when macro AXI_READ_DATA_BUFFER_STATS_EN is defined, add outputs stat_beat_count (32 bits) and stat_burst_count (16 bits).
REQ-025 SHALL, with AXI_READ_DATA_BUFFER_STATS_EN defined, increment stat_beat_count on every pop and stat_burst_count on every pop with m_axi_r_last = 1; both wrap modulo 2^width and reset to 0.
REQ-026 SHALL, without AXI_READ_DATA_BUFFER_STATS_EN, omit both stat ports and all counter logic; the rest of the behaviour is identical.

Verification
REQ-027 SHALL cover: reset, then a 4-beat burst (id=0x05, data 0x10..0x13, last on beat 4) with m_axi_r_ready held at 1 -> beats appear in order, each one cycle after its push, and fifo_count never exceeds 1.
REQ-028 SHALL cover: FIFO_DEPTH=4 with m_axi_r_ready=0 and 6 offered beats -> 4 accepted, s_axi_r_ready=0 and fifo_count=4; then m_axi_r_ready=1 -> all 6 beats delivered in order.
REQ-029 SHALL cover: full, with s_axi_r_valid=1 and one pop -> no push in the pop cycle, fifo_count=3, push in the next cycle restores count to 4.
REQ-030 SHALL cover: a stall with m_axi_r_ready=0 for 3 cycles with head data 0xAA -> m_axi_r_data stays 0xAA and m_axi_r_valid stays 1 throughout.
REQ-031 SHALL cover: reset asserted with 3 beats buffered -> next cycle fifo_count=0, m_axi_r_valid=0, s_axi_r_ready=1, and no stale beat is ever emitted.
REQ-032 SHALL cover, with AXI_READ_DATA_BUFFER_STATS_EN defined: two bursts of lengths 4 and 1 fully drained -> stat_beat_count=5 and stat_burst_count=2.
